// File: rtl/iir_filter_mc.sv
// Multi-channel first-order IIR smoother, y += (x - y) >>> SHIFT, 2-cycle latency.
// Optional macro IIR_FILTER_MC_PRIME_EN: first sample to a channel loads its state.
module iir_filter_mc #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 4,
    parameter int SHIFT    = 4,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_channel,
    input  logic signed [DATA_W-1:0] in_sample,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_channel,
    output logic signed [DATA_W-1:0] out_data
);
    localparam int NCH = 1 << CH_W;
    localparam logic [NCH-1:0] CH_OK = NCH'((64'd1 << CHANNELS) - 64'd1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t state, state_nx;
    logic [CH_W-1:0] sw_idx, sw_idx_nx;
    logic sw_last;
    logic take;

    logic                     s1_valid;
    logic [CH_W-1:0]          s1_ch;
    logic signed [DATA_W-1:0] s1_sample;
    logic                     s2_valid;
    logic [CH_W-1:0]          s2_ch;
    logic signed [DATA_W-1:0] s2_data;

    logic signed [DATA_W-1:0] y [NCH];
    logic signed [DATA_W-1:0] y_cur, y_filt, y_new;
    logic signed [DATA_W:0]   d, d_sh;

    assign in_ready = enable & (state == IDLE) & reset;
    assign take     = in_valid & in_ready;
    assign sw_last  = (sw_idx == CH_W'(CHANNELS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sw_idx <= '0;
        end else begin
            state  <= state_nx;
            sw_idx <= sw_idx_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sw_idx_nx = sw_idx;
        unique case (state)
            IDLE: begin
                if (clear) begin
                    state_nx  = SWEEP;
                    sw_idx_nx = '0;
                end
            end
            SWEEP: begin
                sw_idx_nx = sw_idx + 1'b1;
                if (sw_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The state read here always reflects the previous same-channel update,
    // because the update is written on the same edge that retires this stage.
    assign y_cur  = y[s1_ch];
    assign d      = {s1_sample[DATA_W-1], s1_sample} - {y_cur[DATA_W-1], y_cur};
    assign d_sh   = d >>> SHIFT;
    assign y_filt = DATA_W'(d_sh + {y_cur[DATA_W-1], y_cur});

`ifdef IIR_FILTER_MC_PRIME_EN
    logic [NCH-1:0] primed;

    assign y_new = primed[s1_ch] ? y_filt : s1_sample;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            primed <= '0;
        end else begin
            if (s1_valid) primed[s1_ch] <= 1'b1;
            if (state == SWEEP) primed[sw_idx] <= 1'b0;
        end
    end
`else
    assign y_new = y_filt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_sample <= '0;
        end else begin
            s1_valid <= take & CH_OK[in_channel];
            if (take) begin
                s1_ch     <= in_channel;
                s1_sample <= in_sample;
            end
        end
    end

    // Sweep write is last so it wins a collision with an in-flight sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) y[i] <= '0;
        end else begin
            if (s1_valid) y[s1_ch] <= y_new;
            if (state == SWEEP) y[sw_idx] <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid    <= 1'b0;
            s2_ch       <= '0;
            s2_data     <= '0;
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_data    <= '0;
        end else begin
            s2_valid    <= s1_valid;
            s2_ch       <= s1_ch;
            s2_data     <= y_new;
            out_valid   <= s2_valid;
            out_channel <= s2_ch;
            out_data    <= s2_data;
        end
    end

endmodule

// File: doc/iir_filter_mc.md
IIR_FILTER_MC -- requirements
Module: iir_filter_mc

Interface
REQ-001 Parameter: DATA_W, 16, signed sample and state width in bits (8..32).
REQ-002 Parameter: CHANNELS, 4, number of independent filter channels (1..16); CH_W = max(1, clog2(CHANNELS)).
REQ-003 Parameter: SHIFT, 4, attenuation shift k; filter gain = 2^-k (0..DATA_W-1).
REQ-004 Port: clk  input  1  single clock; all logic rising-edge.
REQ-005 Port: reset  input  1  asynchronous, active-low; asserted when low.
REQ-006 Port: enable  input  1  high = accept new samples; low = in_ready low, pipeline drains.
REQ-007 Port: clear  input  1  one-cycle pulse; starts a sweep that zeroes all channel states.
REQ-008 Port: in_valid  input  1  sample present.
REQ-009 Port: in_ready  output  1  block can accept a sample this cycle.
REQ-010 Port: in_channel  input  CH_W  channel index of sample.
REQ-011 Port: in_sample  input  DATA_W  signed raw sample.
REQ-012 Port: out_valid  output  1  one-cycle strobe, filtered result present.
REQ-013 Port: out_channel  output  CH_W  channel index of result.
REQ-014 Port: out_data  output  DATA_W  signed filtered result.

Function
REQ-015 Transfer occurs on a rising edge with in_valid and in_ready both high; no other cycle alters channel state.
REQ-016 Per channel c: d = in_sample - y[c] computed at DATA_W+1 bits signed; y'[c] = y[c] + (d >>> SHIFT), arithmetic (floor) shift; result truncated to DATA_W, provably lossless.
REQ-017 y'[c] is written to channel state and driven on out_data; out_valid is high exactly 2 cycles after the transfer edge, with out_channel = in_channel.
REQ-018 Throughput: one sample per cycle on any channel mix; no downstream backpressure.
REQ-019 Back-to-back samples to the same channel, including every cycle, use the forwarded in-flight y' with no stall; results equal strictly sequential evaluation.
REQ-020 Out-of-range in_channel (>= CHANNELS) is accepted; no state changes; out_valid is not asserted for that sample.
REQ-021 in_ready = enable AND NOT sweeping AND reset deasserted.
REQ-022 Sweep FSM states IDLE, SWEEP; clear in IDLE -> SWEEP; in SWEEP zero one channel per cycle from 0 to CHANNELS-1, then -> IDLE; total CHANNELS cycles.
REQ-023 clear while in SWEEP is ignored; samples already in the pipeline when clear rises complete and emit normally, and a sweep write that collides with them wins (channel ends at zero).
REQ-024 With SHIFT = 0, out_data equals in_sample.

Reset
REQ-025 Reset low: all y[c] = 0, FSM = IDLE, pipeline valid bits = 0, out_valid = 0, out_channel = 0, out_data = 0, in_ready = 0.
REQ-026 Reset asserted mid-pipeline discards in-flight samples; no out_valid for them after release.
REQ-027 First accepted transfer possible on the first rising edge after reset release with enable high.

Configuration
REQ-028 Macro IIR_FILTER_MC_PRIME_EN defined: per-channel primed flag, cleared by reset and sweep; first sample to an unprimed channel sets y[c] = in_sample, outputs in_sample, and sets primed.
REQ-029 Macro absent: no primed flags; every sample uses REQ-016 from zero-initialised state.

Verification
REQ-030 SHIFT=4, ch0 from reset, samples 1600, 1600 -> out_data 100 then 193, each 2 cycles after its transfer.
REQ-031 SHIFT=4, ch1 from reset, samples -16 then -1 -> out_data -1 then -1 (floor behaviour).
REQ-032 SHIFT=4, DATA_W=16, ch2 fed 32767 for 300 consecutive cycles -> monotone rise, no wrap, settles at 32752 (= 32767 - (2^SHIFT - 1)).
REQ-033 Interleave ch0, ch0, ch3, ch0 every cycle with 160 each -> ch0 outputs 10, 19, 27; ch3 outputs 10; matches a sequential model.
REQ-034 clear pulse after priming ch0..3 -> in_ready low for exactly CHANNELS cycles; next sample 160 on ch0 -> out_data 10 (without macro) or 160 (with macro).
REQ-035 Reset asserted one cycle after a transfer -> no out_valid; all outputs zero while reset is low.
